rx_handshake_ctrl: RTL and testbench
====================================

// Module: rx_handshake_ctrl
// PURPOSE
//  Completes the receiver's four-phase req/ack handshake and buffers each received byte in a small FIFO.
//  Presents the buffered bytes to the host as a valid/ready stream.
//  Sits between the UART receiver and the consuming logic. Decouples receiver byte timing from consumer stalls.
//  Reports overruns and handshake timeouts.
// PARAMETERS
//  DEPTH    4     FIFO entries; power of two, >=2
//  TIMEOUT  1023  max cycles ack stays high waiting for rx_req low before abort
// PORTS
//  clk        in   1  system clock
//  clr        in   1  reset; asynchronous, active-high
//  rx_req     in   1  receiver byte-ready request (held high until ack seen)
//  rx_data    in   8  receiver byte; stable while rx_req=1
//  rx_ack     out  1  acknowledge to receiver
//  out_valid  out  1  FIFO not empty
//  out_data   out  8  FIFO head byte; valid when out_valid=1
//  out_ready  in   1  consumer pops head when out_valid&out_ready
//  fifo_level out  clog2(DEPTH)+1  current occupancy
//  overrun    out  1  sticky: byte dropped because FIFO full
//  ovr_count  out  8  dropped-byte count, saturates at 255
//  hs_timeout out  1  sticky: handshake aborted by TIMEOUT
//  clear_err  in   1  sync clear of overrun, ovr_count, hs_timeout
// BEHAVIOUR
//  Reset: rx_ack=0, FIFO empty (out_valid=0, fifo_level=0), out_data=0, overrun=0, ovr_count=0,
//   hs_timeout=0, FSM=IDLE, timeout counter=0. All outputs registered.
//  FSM: IDLE -> ACK_HI -> RELEASE -> IDLE.
//  IDLE: rx_ack=0. When rx_req=1, take one capture decision in this cycle:
//   - FIFO has room: push rx_data.
//   - FIFO full and a pop occurs this cycle: room counts as available; push.
//   - FIFO full and no pop: drop the byte; set overrun; increment ovr_count (saturating).
//   Then go to ACK_HI. rx_ack=1 from the next cycle.
//  ACK_HI: rx_ack=1; timeout counter increments each cycle.
//   - rx_req=0: go to RELEASE; clear the counter.
//   - Counter reaches TIMEOUT with rx_req still 1: set hs_timeout; go to RELEASE.
//  RELEASE: rx_ack=0 registered; go to IDLE on the next cycle. Never capture in RELEASE.
//  Exactly one push or drop per handshake. No capture until a full return through RELEASE.
//  Push-to-out_valid latency: 1 cycle (byte pushed at edge N, out_valid=1 after edge N).
//  Pop: on out_valid&out_ready; head advances at the edge.
//   Pop on empty: ignored (no pointer change).
//  Simultaneous push and pop, FIFO not full: level unchanged, both pointers advance.
//  Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
//   Full and empty are distinguished by fifo_level, not by pointer compare.
//  clear_err together with a new overrun event in the same cycle: clear applies first, then the event.
//   Result: overrun=1, ovr_count=1.
//  Reset mid-handshake: rx_ack drops at once. If rx_req is still 1 after reset, IDLE captures it as a new byte.
//   The FIFO was cleared, so no duplicate is held.
// STRUCTURE
//  Shared package: FSM state encoding (IDLE, ACK_HI, RELEASE), DATA_W=8, OVR_MAX=255.
//  One sub-module: byte_fifo. Sync FIFO, DEPTH x 8. Ports: push, pop, wdata, rdata, level, full, empty.
//   Registered storage. Pop-when-full-with-push rule is applied in this block's control.
//  Top: FSM, timeout counter, error flags/counter, byte_fifo instance.
// TESTING
//  1 Single byte: rx_req=1 with rx_data=0xA5, out_ready=0.
//    -> rx_ack=1 next cycle; drop rx_req -> rx_ack=0 one cycle later; out_valid=1, out_data=0xA5, fifo_level=1.
//  2 Fill then drop: DEPTH+1 handshakes (0x01..0x05), out_ready=0.
//    -> fifo_level=4, overrun=1, ovr_count=1. Then drain gives 0x01..0x04 in order.
//  3 Full with pop: FIFO full, rx_req=1 (0x77) in the same cycle as out_ready=1.
//    -> no overrun; fifo_level stays 4; 0x77 is last out.
//  4 Timeout: hold rx_req=1 for 1100 cycles.
//    -> hs_timeout=1 at cycle TIMEOUT+1; rx_ack=0; exactly one byte pushed.
//  5 Saturation/clear: 300 drops -> ovr_count=255. Then clear_err coincident with a drop -> ovr_count=1, overrun=1.
//  6 Async reset asserted in ACK_HI -> rx_ack=0 and fifo_level=0 before the next clk edge.

Source files
------------

// File: rtl/rx_handshake_ctrl_pkg.sv
// Shared types and constants for the receive handshake controller.
package rx_handshake_ctrl_pkg;

    localparam int unsigned DATA_W  = 8;
    localparam int unsigned OVR_W   = 8;
    localparam int unsigned OVR_MAX = 255;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACK_HI  = 2'd1,
        RELEASE = 2'd2
    } hs_state_e;

    // Saturating increment for the dropped-byte counter.
    function automatic logic [OVR_W-1:0] sat_inc(input logic [OVR_W-1:0] v);
        return (v == OVR_W'(OVR_MAX)) ? v : v + OVR_W'(1);
    endfunction

endpackage

// File: rtl/rx_handshake_ctrl_byte_fifo.sv
// Synchronous byte FIFO; a push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
module byte_fifo
    import rx_handshake_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DATA_W-1:0]        wdata,
    output logic [DATA_W-1:0]        rdata,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_pop_c;
    logic              do_push_c;

    assign do_pop_c  = pop && !empty;
    assign do_push_c = push && (!full || do_pop_c);
    assign rdata     = mem[rd_ptr];

    // Storage, pointers and occupancy; full/empty follow the level, not a pointer compare.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push_c) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop_c) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({do_push_c, do_pop_c})
                2'b10: begin
                    level <= level + LW'(1);
                    empty <= 1'b0;
                    full  <= (level == LW'(DEPTH - 1));
                end
                2'b01: begin
                    level <= level - LW'(1);
                    full  <= 1'b0;
                    empty <= (level == LW'(1));
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/rx_handshake_ctrl.sv
// Four-phase req/ack receiver handshake feeding a byte FIFO exposed as a valid/ready stream,
// with sticky overrun / handshake-timeout reporting.
module rx_handshake_ctrl
    import rx_handshake_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic                    clk,
    input  logic                    clr,
    input  logic                    rx_req,
    input  logic [DATA_W-1:0]       rx_data,
    output logic                    rx_ack,
    output logic                    out_valid,
    output logic [DATA_W-1:0]       out_data,
    input  logic                    out_ready,
    output logic [$clog2(DEPTH):0]  fifo_level,
    output logic                    overrun,
    output logic [OVR_W-1:0]        ovr_count,
    output logic                    hs_timeout,
    input  logic                    clear_err
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    hs_state_e         state;
    logic [TW-1:0]     to_cnt;
    logic              stale;
    logic              fifo_full;
    logic              fifo_empty;
    logic              pop_c;
    logic              capture_c;
    logic              room_c;
    logic              push_c;
    logic              drop_c;
    logic              timeout_c;

    assign out_valid = !fifo_empty;
    assign pop_c     = out_valid && out_ready;
    assign capture_c = (state == IDLE) && rx_req && !stale;
    assign room_c    = !fifo_full || pop_c;
    assign push_c    = capture_c && room_c;
    assign drop_c    = capture_c && !room_c;
    assign timeout_c = (state == ACK_HI) && rx_req && (to_cnt == TW'(TIMEOUT - 1));

    byte_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (clr),
        .push  (push_c),
        .pop   (pop_c),
        .wdata (rx_data),
        .rdata (out_data),
        .level (fifo_level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Handshake FSM with registered ack and the ACK_HI timeout counter.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state  <= IDLE;
            rx_ack <= 1'b0;
            to_cnt <= '0;
            stale  <= 1'b0;
        end else begin
            // A request held through an abort is the same byte; wait for it to drop first.
            if (!rx_req) begin
                stale <= 1'b0;
            end else if (timeout_c) begin
                stale <= 1'b1;
            end

            unique case (state)
                IDLE: begin
                    rx_ack <= 1'b0;
                    if (capture_c) begin
                        state  <= ACK_HI;
                        rx_ack <= 1'b1;
                        to_cnt <= '0;
                    end
                end
                ACK_HI: begin
                    if (!rx_req || timeout_c) begin
                        state  <= RELEASE;
                        rx_ack <= 1'b0;
                        to_cnt <= '0;
                    end else begin
                        to_cnt <= to_cnt + TW'(1);
                    end
                end
                RELEASE: begin
                    rx_ack <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    rx_ack <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    // Error flags: a same-cycle clear is applied before any new event.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            overrun    <= 1'b0;
            ovr_count  <= '0;
            hs_timeout <= 1'b0;
        end else begin
            if (clear_err) begin
                overrun    <= 1'b0;
                ovr_count  <= '0;
                hs_timeout <= 1'b0;
            end
            if (drop_c) begin
                overrun   <= 1'b1;
                ovr_count <= clear_err ? OVR_W'(1) : sat_inc(ovr_count);
            end
            if (timeout_c) begin
                hs_timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rx_handshake_ctrl.sv
// Randomized and directed bench for rx_handshake_ctrl with a queue-based reference model and scoreboard.
module tb_rx_handshake_ctrl;

    localparam int unsigned DEPTH   = 4;
    localparam int unsigned TIMEOUT = 1023;

    logic       clk = 1'b0;
    logic       clr;
    logic       rx_req;
    logic [7:0] rx_data;
    logic       rx_ack;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;
    logic [2:0] fifo_level;
    logic       overrun;
    logic [7:0] ovr_count;
    logic       hs_timeout;
    logic       clear_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rx_handshake_ctrl #(
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk        (clk),
        .clr        (clr),
        .rx_req     (rx_req),
        .rx_data    (rx_data),
        .rx_ack     (rx_ack),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .fifo_level (fifo_level),
        .overrun    (overrun),
        .ovr_count  (ovr_count),
        .hs_timeout (hs_timeout),
        .clear_err  (clear_err)
    );

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference model: bytes held (scoreboard), handshake phase, ack age, error state.
    logic [7:0] q[$];
    int         m_phase;   // 0 waiting for request, 1 acknowledged, 2 releasing
    int         m_age;
    bit         m_stale;
    bit         m_ovr;
    bit         m_to;
    int         m_cnt;
    bit         m_pop;
    bit         m_cap;
    bit         m_tmo;

    always @(posedge clk or posedge clr) begin
        if (clr) begin
            q.delete();
            m_phase = 0;
            m_age   = 0;
            m_stale = 0;
            m_ovr   = 0;
            m_to    = 0;
            m_cnt   = 0;
        end else begin
            m_pop = (q.size() > 0) && out_ready;
            m_cap = (m_phase == 0) && rx_req && !m_stale;
            m_tmo = 0;
            if (clear_err) begin
                m_ovr = 0;
                m_cnt = 0;
                m_to  = 0;
            end
            if (m_pop) void'(q.pop_front());
            if (m_cap) begin
                if (q.size() < DEPTH) q.push_back(rx_data);
                else begin
                    m_ovr = 1;
                    m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
                end
            end
            case (m_phase)
                0: if (m_cap) begin m_phase = 1; m_age = 0; end
                1: begin
                    if (!rx_req) m_phase = 2;
                    else begin
                        m_age++;
                        if (m_age == int'(TIMEOUT)) begin
                            m_tmo = 1;
                            m_to  = 1;
                            m_phase = 2;
                        end
                    end
                end
                default: m_phase = 0;
            endcase
            if (!rx_req) m_stale = 0;
            else if (m_tmo) m_stale = 1;
        end
    end

    // Monitor: compares every presented output against the model between edges.
    always @(negedge clk) begin
        if (!clr) begin
            chk("rx_ack", 32'(rx_ack), 32'(m_phase == 1));
            chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
            chk("fifo_level", 32'(fifo_level), 32'(q.size()));
            if (out_valid && q.size() > 0) chk("out_data", 32'(out_data), 32'(q[0]));
            chk("overrun", 32'(overrun), 32'(m_ovr));
            chk("ovr_count", 32'(ovr_count), 32'(m_cnt));
            chk("hs_timeout", 32'(hs_timeout), 32'(m_to));
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        clr = 1'b1;
        rx_req = 1'b0;
        out_ready = 1'b0;
        clear_err = 1'b0;
        step();
        clr = 1'b0;
    endtask

    // One complete receiver handshake, bounded waits on each ack transition.
    task automatic hs(input logic [7:0] d);
        bit ok;
        rx_req  = 1'b1;
        rx_data = d;
        ok = 0;
        for (int i = 0; i < 8 && !ok; i++) begin
            step();
            ok = (rx_ack === 1'b1);
        end
        chk("hs_ack_rise", 32'(ok), 32'(1));
        rx_req = 1'b0;
        ok = 0;
        for (int i = 0; i < 8 && !ok; i++) begin
            step();
            ok = (rx_ack === 1'b0);
        end
        chk("hs_ack_fall", 32'(ok), 32'(1));
        step();
    endtask

    task automatic drain_expect(input logic [7:0] b0, input logic [7:0] b1,
                                input logic [7:0] b2, input logic [7:0] b3);
        logic [7:0] exp [4];
        exp[0] = b0; exp[1] = b1; exp[2] = b2; exp[3] = b3;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_data", 32'(out_data), 32'(exp[i]));
            step();
        end
        out_ready = 1'b0;
        chk("drain_empty", 32'(out_valid), 32'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int first;
        rx_data = 8'h00;
        do_reset();

        // Randomized traffic: slow consumer first to provoke overruns, then a fast one.
        for (int c = 0; c < 4000; c++) begin
            out_ready = ($urandom_range(0, 99) < ((c < 2000) ? 20 : 70));
            clear_err = ($urandom_range(0, 99) < 3);
            if (!rx_req && !rx_ack && $urandom_range(0, 3) == 0) begin
                rx_req  = 1'b1;
                rx_data = 8'($urandom);
            end else if (rx_req && rx_ack && $urandom_range(0, 1) == 0) begin
                rx_req = 1'b0;
            end
            step();
        end
        rx_req = 1'b0;
        clear_err = 1'b0;
        out_ready = 1'b1;
        repeat (10) step();

        // Single byte and reset values.
        do_reset();
        chk("rst_rx_ack", 32'(rx_ack), 32'(0));
        chk("rst_out_valid", 32'(out_valid), 32'(0));
        chk("rst_level", 32'(fifo_level), 32'(0));
        chk("rst_out_data", 32'(out_data), 32'(0));
        chk("rst_overrun", 32'(overrun), 32'(0));
        chk("rst_ovr_count", 32'(ovr_count), 32'(0));
        chk("rst_hs_timeout", 32'(hs_timeout), 32'(0));
        rx_req = 1'b1;
        rx_data = 8'hA5;
        step();
        chk("t1_ack_hi", 32'(rx_ack), 32'(1));
        rx_req = 1'b0;
        step();
        chk("t1_ack_lo", 32'(rx_ack), 32'(0));
        chk("t1_valid", 32'(out_valid), 32'(1));
        chk("t1_data", 32'(out_data), 32'hA5);
        chk("t1_level", 32'(fifo_level), 32'(1));
        step();

        // Fill then drop.
        do_reset();
        for (int i = 1; i <= 5; i++) hs(8'(i));
        chk("t2_level", 32'(fifo_level), 32'(4));
        chk("t2_overrun", 32'(overrun), 32'(1));
        chk("t2_ovr_count", 32'(ovr_count), 32'(1));
        drain_expect(8'h01, 8'h02, 8'h03, 8'h04);

        // Full FIFO with a pop in the capture cycle.
        do_reset();
        for (int i = 0; i < 4; i++) hs(8'(8'h10 + i));
        rx_req = 1'b1;
        rx_data = 8'h77;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("t3_overrun", 32'(overrun), 32'(0));
        chk("t3_level", 32'(fifo_level), 32'(4));
        rx_req = 1'b0;
        repeat (3) step();
        drain_expect(8'h11, 8'h12, 8'h13, 8'h77);

        // Handshake timeout with the request held.
        do_reset();
        rx_req = 1'b1;
        rx_data = 8'h5A;
        first = 0;
        for (int k = 1; k <= 1100; k++) begin
            step();
            if (first == 0 && hs_timeout === 1'b1) begin
                first = k;
                chk("t4_ack_lo", 32'(rx_ack), 32'(0));
            end
        end
        chk("t4_cycle", 32'(first), 32'(TIMEOUT + 1));
        chk("t4_one_push", 32'(fifo_level), 32'(1));
        chk("t4_data", 32'(out_data), 32'h5A);
        rx_req = 1'b0;
        repeat (3) step();

        // Saturation, then clear coincident with a drop.
        do_reset();
        for (int i = 0; i < 4; i++) hs(8'(8'hC0 + i));
        for (int i = 0; i < 300; i++) hs(8'(i));
        chk("t5_sat", 32'(ovr_count), 32'(255));
        chk("t5_overrun", 32'(overrun), 32'(1));
        rx_req = 1'b1;
        rx_data = 8'hEE;
        clear_err = 1'b1;
        step();
        clear_err = 1'b0;
        chk("t5_clr_count", 32'(ovr_count), 32'(1));
        chk("t5_clr_overrun", 32'(overrun), 32'(1));
        rx_req = 1'b0;
        repeat (3) step();

        // Asynchronous reset while acknowledged; held request is recaptured afterwards.
        rx_req = 1'b1;
        rx_data = 8'h3C;
        step();
        chk("t6_in_ack", 32'(rx_ack), 32'(1));
        clr = 1'b1;
        #1;
        chk("t6_ack_async", 32'(rx_ack), 32'(0));
        chk("t6_level_async", 32'(fifo_level), 32'(0));
        step();
        clr = 1'b0;
        step();
        chk("t6_recapture_valid", 32'(out_valid), 32'(1));
        chk("t6_recapture_data", 32'(out_data), 32'h3C);
        chk("t6_recapture_level", 32'(fifo_level), 32'(1));
        rx_req = 1'b0;
        repeat (3) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
